// File: rtl/ext_data_memory.sv
// Off-chip 256-bit line memory responder: one request in flight, acknowledged
// LATENCY cycles after acceptance with a single-cycle ack pulse.
module ext_data_memory #(
   parameter int DEPTH   = 512,
   parameter int LATENCY = 10
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [31:0]  addr_i,
   input  logic         cs,
   input  logic         we,
   input  logic [255:0] data_i,
   output logic [255:0] data_o,
   output logic         ack
);
   localparam int IW = $clog2(DEPTH);
   localparam int CW = $clog2(LATENCY) + 1;
   localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

   typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

   state_t        state;
   logic [CW-1:0] count;
   logic [IW-1:0] req_idx;
   logic          req_we;
   logic [255:0]  req_data;
   logic [255:0]  mem [DEPTH];
   logic          commit;
   logic          unused_addr;

   // Offset bits and bits above the line index carry no meaning here.
   assign unused_addr = ^addr_i;

   // A reset on the would-be ACK edge suppresses the write.
   assign commit = rst && (state == WAIT) && (count == '0) && req_we;

   always_ff @(posedge clk) begin
      if (commit) begin
         mem[req_idx] <= req_data;
      end
   end

   // The edge that ends the ACK cycle may already accept the next request,
   // giving one request per LATENCY+1 cycles with acks never adjacent.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= IDLE;
         ack      <= 1'b0;
         data_o   <= '0;
         count    <= '0;
         req_idx  <= '0;
         req_we   <= 1'b0;
         req_data <= '0;
      end else begin
         case (state)
            IDLE, ACK: begin
               ack <= 1'b0;
               if (cs) begin
                  req_idx  <= addr_i[IW+4:5];
                  req_we   <= we;
                  req_data <= data_i;
                  count    <= CNT_INIT;
                  state    <= WAIT;
               end else begin
                  state <= IDLE;
               end
            end
            WAIT: begin
               if (count == '0) begin
                  if (!req_we) begin
                     data_o <= mem[req_idx];
                  end
                  ack   <= 1'b1;
                  state <= ACK;
               end else begin
                  count <= count - CW'(1);
               end
            end
            default: begin
               ack   <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_ext_data_memory.sv
// Bench for ext_data_memory: a LATENCY=10/DEPTH=512 instance and a LATENCY=1/DEPTH=16
// instance, checked against a line-array reference model.
module tb_ext_data_memory;
   localparam int D0 = 512;
   localparam int L0 = 10;
   localparam int D1 = 16;
   localparam int L1 = 1;

   logic         clk;
   logic         rst;
   logic [31:0]  addr0, addr1;
   logic         cs0, cs1, we0, we1;
   logic [255:0] din0, din1, dout0, dout1;
   logic         ack0, ack1;

   int checks = 0;
   int errors = 0;

   logic [255:0] m0 [D0];
   logic [255:0] m1 [D1];
   logic [255:0] dout0_m, dout1_m;

   ext_data_memory #(.DEPTH(D0), .LATENCY(L0)) dut0 (
      .clk(clk), .rst(rst), .addr_i(addr0), .cs(cs0), .we(we0),
      .data_i(din0), .data_o(dout0), .ack(ack0)
   );

   ext_data_memory #(.DEPTH(D1), .LATENCY(L1)) dut1 (
      .clk(clk), .rst(rst), .addr_i(addr1), .cs(cs1), .we(we1),
      .data_i(din1), .data_o(dout1), .ack(ack1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [255:0] rnd256();
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   function automatic int line_of(input bit s, input logic [31:0] a);
      return s ? int'((a / 32) % D1) : int'((a / 32) % D0);
   endfunction

   task automatic drive(input bit s, input logic c, input logic w,
                        input logic [31:0] a, input logic [255:0] d);
      if (s) begin
         cs1 = c; we1 = w; addr1 = a; din1 = d;
      end else begin
         cs0 = c; we0 = w; addr0 = a; din0 = d;
      end
   endtask

   // Called at a negedge; the following posedge is the acceptance edge.
   task automatic xact(input bit s, input logic w, input logic [31:0] a,
                       input logic [255:0] d, input bit keep, input string tag);
      int n;
      int idx;
      logic [255:0] exp;
      idx = line_of(s, a);
      drive(s, 1'b1, w, a, d);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(s ? ack1 : ack0) && n < 40);
      chk({tag, "_lat"}, 256'(n - 1), 256'(s ? L1 : L0));
      if (w) begin
         exp = s ? dout1_m : dout0_m;
         if (s) m1[idx] = d; else m0[idx] = d;
      end else begin
         exp = s ? m1[idx] : m0[idx];
         if (s) dout1_m = exp; else dout0_m = exp;
      end
      chk({tag, "_dat"}, s ? dout1 : dout0, exp);
      if (!keep) begin
         drive(s, 1'b0, 1'b0, $urandom, rnd256());
         @(negedge clk);
         chk({tag, "_ackoff"}, 256'(s ? ack1 : ack0), 256'(0));
      end
   endtask

   initial begin
      logic any_ack;
      logic [255:0] v;
      rst = 1'b0;
      drive(0, 1'b1, 1'b0, 32'h60, '0);
      drive(1, 1'b0, 1'b0, 32'h0, '0);
      for (int i = 0; i < D0; i++) begin
         m0[i] = rnd256();
         if (i == 3) m0[i] = {32{8'hA5}};
         if (i == 5) m0[i] = '0;
         dut0.mem[i] <= m0[i];
      end
      for (int i = 0; i < D1; i++) begin
         m1[i] = rnd256();
         dut1.mem[i] <= m1[i];
      end
      dout0_m = '0;
      dout1_m = '0;

      // Reset held with a live request: nothing accepted, outputs cleared.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_ack", 256'(ack0), 256'(0));
         chk("rst_dout", dout0, '0);
         chk("rst_ack1", 256'(ack1), 256'(0));
      end
      rst = 1'b1;
      xact(0, 1'b0, 32'h60, '0, 0, "rd_line3");

      // Write then read with offset bits set; data_o must hold across the write.
      xact(0, 1'b1, 32'h20, 256'h1234, 0, "wr_20");
      xact(0, 1'b0, 32'h3F, '0, 0, "rd_3f");

      // Back-to-back reads with cs held: the gap is checked by the latency count.
      xact(0, 1'b0, 32'h00, '0, 1, "b2b_0");
      xact(0, 1'b0, 32'h20, '0, 0, "b2b_1");

      // Reset during the wait of a write: no ack, no commit.
      drive(0, 1'b1, 1'b1, 32'hA0, 256'hFF);
      repeat (5) @(negedge clk);
      rst = 1'b0;
      drive(0, 1'b0, 1'b0, 32'h0, '0);
      @(negedge clk);
      rst = 1'b1;
      dout0_m = '0;
      dout1_m = '0;
      chk("midrst_dout", dout0, '0);
      any_ack = 1'b0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         any_ack = any_ack | ack0;
      end
      chk("midrst_noack", 256'(any_ack), 256'(0));
      xact(0, 1'b0, 32'hA0, '0, 0, "midrst_rd5");

      // Bits above the index are ignored.
      v = rnd256();
      xact(0, 1'b1, 32'h0000_4000, v, 0, "wrap_wr");
      xact(0, 1'b0, 32'h0, '0, 0, "wrap_rd");

      for (int i = 0; i < 30; i++) begin
         xact(0, 1'($urandom_range(0, 1)), $urandom, rnd256(), 0, "rand0");
      end

      // Single-cycle latency instance.
      xact(1, 1'b0, 32'h40, '0, 0, "l1_rd");
      v = rnd256();
      xact(1, 1'b1, 32'h0000_0200, v, 0, "l1_wrap_wr");
      xact(1, 1'b0, 32'h0000_001F, '0, 1, "l1_b2b_a");
      xact(1, 1'b0, 32'h0000_0200, '0, 0, "l1_b2b_b");
      for (int i = 0; i < 25; i++) begin
         xact(1, 1'($urandom_range(0, 1)), $urandom, rnd256(), 0, "rand1");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/ext_data_memory.md
# ext_data_memory

Off-chip data memory model: the responder end of the CPU's external memory interface (256-bit line transfers, chip-select/write-enable request, single-cycle acknowledge). Sits outside the CPU top-level, driven by the L1 data cache's miss/write-back path. It accepts one line request at a time, waits a programmable access latency, then commits the write or returns the read line and pulses acknowledge.

## Interface
- DEPTH, 512: number of 256-bit lines; power of two, ≥ 2.
- LATENCY, 10: cycles from request acceptance to acknowledge; ≥ 1.
- clk  input  1  clock, all state changes on rising edge.
- rst  input  1  synchronous, active-low reset.
- addr_i  input  32  byte address; line index = addr_i[5+log2(DEPTH)-1:5]; bits [4:0] and bits above the index are ignored.
- cs  input  1  request valid; held high with stable addr_i/we/data_i until ack.
- we  input  1  1 = line write, 0 = line read; sampled with cs.
- data_i  input  256  write line.
- data_o  output  256  read line; valid during the ack cycle.
- ack  output  1  one-cycle completion pulse.

## Operation
- States: IDLE, WAIT, ACK.
- IDLE: if cs=1, latch line index, we, data_i into request registers, load counter with LATENCY-1, go to WAIT; else stay.
- WAIT: counter==0 -> go to ACK; otherwise decrement counter. The counter has log2(LATENCY)+1 bits, with no wrap.
- On the edge entering ACK:
  - Write: mem[index] <= latched data; data_o unchanged.
  - Read: data_o <= mem[index].
  - ack <= 1.
- ACK: ack=1 for exactly this cycle; next edge -> IDLE, ack <= 0.
- Back-to-back: cs sampled high in IDLE starts a new request. The earliest new acceptance is the edge after ACK; acknowledges are never adjacent.
- Only the latched request is serviced. Changes on addr_i/we/data_i/cs during WAIT/ACK are ignored, including cs dropping (no abort).
- data_o holds its last read value until the next read completes.
- Memory array is not reset. Contents are undefined until written; the bench preloads via hierarchical access or $readmemh.

## Timing
- Reset (rst=0 at an edge): state=IDLE, ack=0, data_o=0, counter=0, request registers=0. This applies in any state.
- Reset during WAIT aborts the request; a pending write is not committed.
- Reset on the edge that would enter ACK wins: no write, no ack.
- Latency: cs accepted at edge E0 -> ack high between edges E(LATENCY) and E(LATENCY+1).
  - LATENCY=1: IDLE -> WAIT (counter 0) -> ACK at the next edge.
- Throughput: one request per LATENCY+1 cycles maximum.
- Read-after-write to the same line, issued as the next request, returns the new data.
- Write and read in the same request never occur; we selects exactly one.

## Test plan
- Reset: hold rst=0 for 3 cycles with cs=1 -> ack=0 and data_o=0 throughout; no request accepted until the first edge with rst=1.
- Read latency: preload line 3 = 256'hA5..A5. Assert cs=1, we=0, addr_i=32'h60 at E0 -> ack=1 only in the cycle after E10, data_o=A5..A5 in that cycle, ack=0 at E11.
- Write then read: write 256'h1234 to addr_i=32'h20, hold cs until ack, drop cs; then read addr 32'h3F -> returns 256'h1234, confirming bits [4:0] are ignored. data_o unchanged across the write.
- Back-to-back: keep cs=1 continuously for two reads of lines 0 and 1 -> ack pulses separated by exactly LATENCY cycles of ack=0, each with the correct line data.
- Reset mid-write: write 256'hFF to line 5 (old value 256'h0), pull rst low at E5 -> no ack; a subsequent read of line 5 returns 256'h0.
- Address wrap with DEPTH=512: write to addr_i=32'h0000_4000 (index 0, upper bits ignored) -> a read of addr 32'h0 returns the written value. Also run a LATENCY=1 build: ack exactly one cycle after the acceptance edge.
